// File: rtl/example_pkg.sv
// Shared definitions for the 7-state example FSM and its steering companion:
// state encodings, transition/output functions and the shortest-path hop ROM.
package example_pkg;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;

    typedef enum logic {
        CTL_IDLE  = 1'b0,
        CTL_STEER = 1'b1
    } ctl_state_e;

    // Indexed [current][target]; a set bit means the first hop of the
    // shortest path is x=1, ties already resolved towards x=0.
    localparam logic [6:0][6:0] NEXT_HOP_ROM = {
        7'b0000000,   // S6
        7'b1001010,   // S5
        7'b0000100,   // S4
        7'b1000000,   // S3
        7'b0010000,   // S2
        7'b0110100,   // S1
        7'b0010100    // S0
    };

    function automatic logic [2:0] delta(input logic [2:0] s, input logic x);
        logic [2:0] n;
        case (s)
            S0:      n = x ? S2 : S1;
            S1:      n = x ? S5 : S3;
            S2:      n = x ? S4 : S5;
            S3:      n = x ? S6 : S1;
            S4:      n = x ? S2 : S5;
            S5:      n = x ? S3 : S4;
            S6:      n = x ? S6 : S5;
            default: n = S0;
        endcase
        return n;
    endfunction

    function automatic logic model_out(input logic [2:0] s);
        return (s == S0) || (s == S1) || (s == S3);
    endfunction

    function automatic logic next_hop(input logic [2:0] s, input logic [2:0] t);
        if ((s > S6) || (t > S6)) begin
            return 1'b0;
        end
        return NEXT_HOP_ROM[s][t];
    endfunction

endpackage

// File: rtl/example_shadow.sv
// Lockstep shadow of the example FSM state plus the sticky output-mismatch flag.
module example_shadow
    import example_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       x_in,
    input  logic       fsm_out,
    output logic [2:0] shadow_state,
    output logic       desync
);

    logic [2:0] r_state;
    logic       r_desync;
    logic       w_mismatch;

    assign w_mismatch = (fsm_out != model_out(r_state));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S0;
            r_desync <= 1'b0;
        end else begin
            r_state  <= delta(r_state, x_in);
            r_desync <= r_desync | w_mismatch;
        end
    end

    assign shadow_state = r_state;
    assign desync       = r_desync;

endmodule

// File: rtl/example_steer.sv
// Drives the example FSM's x input, steering it along the shortest path to a
// requested state while a shadow copy tracks the FSM in lockstep.
module example_steer
    import example_pkg::*;
#(
    parameter logic IDLE_X    = 1'b0,
    parameter int   MAX_STEPS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_target,
    output logic       req_ready,
    input  logic       fsm_out,
    output logic       x_out,
    output logic [2:0] shadow_state,
    output logic       done,
    output logic [2:0] steps,
    output logic       err,
    output logic       desync
);

    localparam logic [2:0] STEP_LIMIT = 3'(MAX_STEPS);

    ctl_state_e r_ctl;
    ctl_state_e w_ctl_next;
    logic [2:0] r_target;
    logic [2:0] r_cnt;
    logic [2:0] w_target_next;
    logic [2:0] w_cnt_next;
    logic [2:0] w_shadow;
    logic       w_desync;
    logic       w_x;
    logic       w_ready;
    logic       w_done;
    logic       w_err;

    example_shadow u_shadow (
        .clk          (clk),
        .reset        (reset),
        .x_in         (w_x),
        .fsm_out      (fsm_out),
        .shadow_state (w_shadow),
        .desync       (w_desync)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ctl    <= CTL_IDLE;
            r_cnt    <= 3'd0;
            r_target <= S0;
        end else begin
            r_ctl    <= w_ctl_next;
            r_cnt    <= w_cnt_next;
            r_target <= w_target_next;
        end
    end

    // Outputs depend only on registered state; req_* feed next-state alone.
    always_comb begin
        w_ctl_next    = r_ctl;
        w_cnt_next    = r_cnt;
        w_target_next = r_target;
        w_x           = IDLE_X;
        w_ready       = 1'b0;
        w_done        = 1'b0;
        w_err         = 1'b0;
        case (r_ctl)
            CTL_IDLE: begin
                w_ready = !w_desync;
                if (req_valid && w_ready) begin
                    w_target_next = req_target;
                    w_cnt_next    = 3'd0;
                    w_ctl_next    = CTL_STEER;
                end
            end
            CTL_STEER: begin
                // Desync can only be seen here in the cycle it first rises,
                // because IDLE refuses requests once it is set.
                if (w_desync) begin
                    w_err      = 1'b1;
                    w_ctl_next = CTL_IDLE;
                end else if (w_shadow == r_target) begin
                    w_done     = 1'b1;
                    w_ctl_next = CTL_IDLE;
                end else if ((r_target == S0) || (r_target > S6)) begin
                    w_err      = 1'b1;
                    w_ctl_next = CTL_IDLE;
                end else if (r_cnt == STEP_LIMIT) begin
                    w_err      = 1'b1;
                    w_ctl_next = CTL_IDLE;
                end else begin
                    w_x        = next_hop(w_shadow, r_target);
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            default: w_ctl_next = CTL_IDLE;
        endcase
    end

    assign req_ready    = w_ready;
    assign x_out        = w_x;
    assign shadow_state = w_shadow;
    assign done         = w_done;
    assign steps        = r_cnt;
    assign err          = w_err;
    assign desync       = w_desync;

endmodule

// File: tb/tb_example_steer.sv
// Bench for example_steer: a behavioural FSM drives fsm_out, and expected
// paths come from a breadth-first search over the transition table.
module tb_example_steer;

    localparam logic IDLE_X = 1'b0;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       req_valid  = 1'b0;
    logic [2:0] req_target = 3'd0;
    logic       fsm_out;
    logic       req_ready;
    logic       x_out;
    logic [2:0] shadow_state;
    logic       done;
    logic [2:0] steps;
    logic       err;
    logic       desync;

    int checks   = 0;
    int failures = 0;

    int tb_next [7][2] = '{'{1, 2}, '{3, 5}, '{5, 4}, '{1, 6}, '{5, 2}, '{4, 3}, '{5, 6}};
    bit tb_out  [7]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    int   fsm_state = 0;
    logic fsm_x_q   = 1'b0;
    logic inject    = 1'b0;

    example_steer #(
        .IDLE_X    (IDLE_X),
        .MAX_STEPS (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_target   (req_target),
        .req_ready    (req_ready),
        .fsm_out      (fsm_out),
        .x_out        (x_out),
        .shadow_state (shadow_state),
        .done         (done),
        .steps        (steps),
        .err          (err),
        .desync       (desync)
    );

    always #5 clk = ~clk;

    // Behavioural copy of the real FSM being steered.
    always @(negedge clk) fsm_x_q = x_out;

    always @(posedge clk) begin
        if (!reset) fsm_state <= 0;
        else        fsm_state <= tb_next[fsm_state][int'(fsm_x_q)];
    end

    assign fsm_out = tb_out[fsm_state] ^ inject;

    function automatic int dist_to(int s, int t);
        int d [7];
        int q [$];
        int u;
        int v;
        foreach (d[i]) d[i] = -1;
        d[s] = 0;
        q.push_back(s);
        while (q.size() > 0) begin
            u = q.pop_front();
            for (int x = 0; x < 2; x++) begin
                v = tb_next[u][x];
                if (d[v] < 0) begin
                    d[v] = d[u] + 1;
                    q.push_back(v);
                end
            end
        end
        return (t >= 0 && t < 7) ? d[t] : -1;
    endfunction

    function automatic int choose_x(int s, int t);
        int d0;
        int d1;
        d0 = dist_to(tb_next[s][0], t);
        d1 = dist_to(tb_next[s][1], t);
        if (d0 >= 0 && (d1 < 0 || d0 <= d1)) return 0;
        return 1;
    endfunction

    // Called mid-cycle; issues one request and follows it to completion.
    // inj_step >= 0 corrupts fsm_out during that step; rst_step >= 0 asserts
    // reset during that step and returns immediately.
    task automatic run_request(input int tgt, input int inj_step, input int rst_step);
        int s;
        int x;
        int k;
        int wait_cyc;
        int path [$];
        wait_cyc = 0;
        while (req_ready !== 1'b1 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_wait: got %b want 1", req_ready);
            return;
        end
        req_valid  = 1'b1;
        req_target = 3'(tgt);
        checks++;
        if (x_out !== IDLE_X) begin
            failures++;
            $display("FAIL accept_x tgt=%0d: got %b want %b", tgt, x_out, IDLE_X);
        end
        s = tb_next[fsm_state][int'(IDLE_X)];
        if (tgt >= 1 && tgt <= 6) begin
            while (s != tgt && path.size() < 8) begin
                x = choose_x(s, tgt);
                path.push_back(x);
                s = tb_next[s][x];
            end
        end
        k = path.size();
        s = tb_next[fsm_state][int'(IDLE_X)];
        @(negedge clk);
        req_valid = 1'b0;
        if (tgt < 1 || tgt > 6) begin
            checks++;
            if (err !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL unreach_err tgt=%0d: got err=%b done=%b want err=1 done=0", tgt, err, done);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL unreach_recover tgt=%0d: got err=%b ready=%b want 0 1", tgt, err, req_ready);
            end
            return;
        end
        for (int i = 0; i < k; i++) begin
            checks++;
            if (x_out !== path[i][0]) begin
                failures++;
                $display("FAIL x_out tgt=%0d step=%0d: got %b want %0d", tgt, i, x_out, path[i]);
            end
            checks++;
            if (shadow_state !== 3'(s)) begin
                failures++;
                $display("FAIL shadow tgt=%0d step=%0d: got %0d want %0d", tgt, i, shadow_state, s);
            end
            checks++;
            if ({done, err, req_ready} !== 3'b000) begin
                failures++;
                $display("FAIL steer_flags tgt=%0d step=%0d: got done/err/ready=%b want 000", tgt, i, {done, err, req_ready});
            end
            if (i == rst_step) begin
                reset = 1'b0;
                return;
            end
            if (i == inj_step) inject = 1'b1;
            @(negedge clk);
            inject = 1'b0;
            if (i == inj_step) begin
                checks++;
                if ({err, done, desync} !== 3'b101) begin
                    failures++;
                    $display("FAIL desync_abort: got err/done/desync=%b want 101", {err, done, desync});
                end
                return;
            end
            s = tb_next[s][path[i]];
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || steps !== 3'(k)) begin
            failures++;
            $display("FAIL done tgt=%0d: got done=%b err=%b steps=%0d want 1 0 %0d", tgt, done, err, steps, k);
        end
        checks++;
        if (shadow_state !== 3'(tgt)) begin
            failures++;
            $display("FAIL done_shadow: got %0d want %0d", shadow_state, tgt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_done tgt=%0d: got done=%b ready=%b want 0 1", tgt, done, req_ready);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (x_out !== IDLE_X) begin
            failures++;
            $display("FAIL reset_x: got %b want %b", x_out, IDLE_X);
        end
        checks++;
        if (shadow_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_shadow: got %0d want 0", shadow_state);
        end
        checks++;
        if ({done, err, desync} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got done/err/desync=%b want 000", {done, err, desync});
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_first_steer();
        reset = 1'b1;
        run_request(6, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_request(2, -1, -1);
        run_request(3, -1, -1);
        run_request(5, -1, -1);
        run_request(1, -1, -1);
    endtask

    task automatic test_random();
        int gap;
        int tgt;
        for (int n = 0; n < 30; n++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            if ($urandom_range(0, 7) == 0) tgt = ($urandom_range(0, 1) == 0) ? 0 : 7;
            else                           tgt = int'($urandom_range(1, 6));
            run_request(tgt, -1, -1);
        end
    endtask

    task automatic test_unreachable();
        run_request(0, -1, -1);
        run_request(7, -1, -1);
    endtask

    task automatic test_desync();
        int s1;
        int best;
        s1   = tb_next[fsm_state][int'(IDLE_X)];
        best = 1;
        for (int t = 1; t < 7; t++) begin
            if (dist_to(s1, t) > dist_to(s1, best)) best = t;
        end
        run_request(best, 0, -1);
        req_valid  = 1'b1;
        req_target = 3'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({desync, req_ready, done, err} !== 4'b1000) begin
                failures++;
                $display("FAIL desync_hold cyc=%0d: got desync/ready/done/err=%b want 1000", i, {desync, req_ready, done, err});
            end
            checks++;
            if (x_out !== IDLE_X) begin
                failures++;
                $display("FAIL desync_x cyc=%0d: got %b want %b", i, x_out, IDLE_X);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_request(2, -1, 2);
        @(negedge clk);
        checks++;
        if (shadow_state !== 3'd0 || x_out !== IDLE_X) begin
            failures++;
            $display("FAIL reset_mid_state: got shadow=%0d x=%b want 0 %b", shadow_state, x_out, IDLE_X);
        end
        checks++;
        if ({done, err, desync, req_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_flags: got done/err/desync/ready=%b want 0001", {done, err, desync, req_ready});
        end
        reset = 1'b1;
        run_request(6, -1, -1);
    endtask

    initial begin
        test_reset();
        test_first_steer();
        test_back_to_back();
        test_unreachable();
        test_random();
        test_desync();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
